// File: rtl/uart_tx_param.sv
// RS-232 transmitter: start bit, 5..MAX_BITS data bits LSB first, optional parity,
// and 1 or 2 stop bits, timed by an external oversample tick.
module uart_tx_param #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned MAX_BITS   = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                tick,
    input  logic                TxValid,
    output logic                TxReady,
    input  logic [MAX_BITS-1:0] TxData,
    input  logic [3:0]          nBits,
    input  logic [1:0]          ParityMode,
    input  logic                StopBits,
    output logic                Tx,
    output logic                TxDone,
    output logic                Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          tick_cnt_q, tick_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [3:0]          nbits_q, nbits_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                two_stop_q, two_stop_d;
    logic                tx_q, tx_d;

    logic                accept;
    logic                bit_end;
    logic                done;
    logic [3:0]          nbits_eff;
    logic [MAX_BITS-1:0] data_mask;
    logic [MAX_BITS-1:0] data_masked;

    always_comb begin
        nbits_eff = 4'(MAX_BITS);
        if (nBits >= 4'd5 && nBits <= 4'(MAX_BITS)) begin
            nbits_eff = nBits;
        end
        data_mask = '0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            data_mask[i] = (i < 32'(nbits_eff));
        end
        data_masked = TxData & data_mask;
    end

    assign accept  = TxValid && (state_q == S_IDLE);
    assign bit_end = tick && (state_q != S_IDLE) && (tick_cnt_q == 6'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        done       = 1'b0;

        // Bit timing restarts on every bit boundary, so it is cleared whenever a bit ends.
        if (state_q != S_IDLE && tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d       = 1'b1;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (accept) begin
                    shift_d    = data_masked;
                    nbits_d    = nbits_eff;
                    par_en_d   = (ParityMode == 2'b01) || (ParityMode == 2'b10);
                    par_bit_d  = (^data_masked) ^ (ParityMode == 2'b10);
                    two_stop_d = StopBits;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = nbits_q;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 4'd1) begin
                        if (par_en_q) begin
                            state_d   = S_PARITY;
                            tx_d      = par_bit_q;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = S_STOP;
                            tx_d      = 1'b1;
                            bit_cnt_d = two_stop_q ? 4'd2 : 4'd1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = two_stop_q ? 4'd2 : 4'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == 4'd1) begin
                        done      = 1'b1;
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    assign Tx      = tx_q;
    assign TxReady = (state_q == S_IDLE);
    assign Busy    = (state_q != S_IDLE);
    assign TxDone  = done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed frame table, back-to-back and reset sequences,
// and random frames checked cycle by cycle against a bit-list reference model.
module tb_uart_tx_param;

    localparam int OS = 16;

    logic       Clk        = 1'b0;
    logic       Rst_n      = 1'b0;
    logic       tick       = 1'b0;
    logic       TxValid    = 1'b0;
    logic [7:0] TxData     = '0;
    logic [3:0] nBits      = 4'd8;
    logic [1:0] ParityMode = '0;
    logic       StopBits   = 1'b0;
    logic       TxReady, Tx, TxDone, Busy;

    int tests = 0;
    int fails = 0;

    bit exp_bits[$];

    always #5 Clk = ~Clk;

    uart_tx_param #(.OVERSAMPLE(OS), .MAX_BITS(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .tick(tick), .TxValid(TxValid), .TxReady(TxReady),
        .TxData(TxData), .nBits(nBits), .ParityMode(ParityMode), .StopBits(StopBits),
        .Tx(Tx), .TxDone(TxDone), .Busy(Busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    function automatic void build_frame(input logic [7:0] d, input logic [3:0] nb,
                                        input logic [1:0] pm, input logic sb);
        int n;
        int ones;
        n    = (nb >= 4'd5 && nb <= 4'd8) ? int'(nb) : 8;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm == 2'b01) exp_bits.push_back(bit'(ones % 2));
        else if (pm == 2'b10) exp_bits.push_back(bit'(1 - ones % 2));
        exp_bits.push_back(1'b1);
        if (sb) exp_bits.push_back(1'b1);
    endfunction

    // period 0 = random ticks; inputs are scrambled every cycle after accept.
    task automatic frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] pm,
                         input logic sb, input int period, input bit hold, output int done_cyc);
        int  seen;
        int  total;
        bit  exp_done;
        seen = 0;
        build_frame(d, nb, pm, sb);
        total = exp_bits.size() * OS;
        chk1("ready_before_accept", TxReady, 1'b1);
        TxData = d; nBits = nb; ParityMode = pm; StopBits = sb;
        TxValid = 1'b1;
        tick = 1'b1;
        @(posedge Clk); #1;
        chk1("tx_at_accept", Tx, 1'b0);
        chk1("busy_at_accept", Busy, 1'b1);
        chk1("ready_at_accept", TxReady, 1'b0);
        done_cyc = -1;
        for (int c = 0; c < total * 8 + 50; c++) begin
            tick       = (period == 0) ? ($urandom_range(0, 2) == 0) : (c % period == 0);
            TxData     = 8'($urandom);
            nBits      = 4'($urandom);
            ParityMode = 2'($urandom);
            StopBits   = 1'($urandom);
            TxValid    = hold ? 1'b1 : 1'($urandom);
            @(negedge Clk);
            exp_done = tick && (seen == total - 1);
            chk1("tx_bit", Tx, exp_bits[seen / OS]);
            chk1("busy_in_frame", Busy, 1'b1);
            chk1("ready_in_frame", TxReady, 1'b0);
            chk1("txdone", TxDone, exp_done);
            @(posedge Clk); #1;
            if (tick) seen++;
            if (exp_done) begin
                done_cyc = c + 1;
                break;
            end
        end
        chkn("frame_ticks_consumed", seen, total);
        TxValid = hold;
        tick = 1'b0;
        chk1("tx_after_done", Tx, 1'b1);
        chk1("ready_after_done", TxReady, 1'b1);
        chk1("busy_after_done", Busy, 1'b0);
        chk1("txdone_after_done", TxDone, 1'b0);
    endtask

    task automatic idle(input int n);
        TxValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick = 1'($urandom);
            @(negedge Clk);
            chk1("idle_tx", Tx, 1'b1);
            chk1("idle_ready", TxReady, 1'b1);
            chk1("idle_busy", Busy, 1'b0);
            chk1("idle_txdone", TxDone, 1'b0);
            @(posedge Clk); #1;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [3:0] nb;
        logic [1:0] pm;
        logic       sb;
        int         period;
        int         exp_len;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   dc;
        bit   hold;

        vecs[0] = '{8'h55, 4'd8,  2'b00, 1'b0, 1, 10};
        vecs[1] = '{8'hC1, 4'd7,  2'b01, 1'b1, 1, 11};
        vecs[2] = '{8'h41, 4'd8,  2'b10, 1'b0, 1, 11};
        vecs[3] = '{8'h41, 4'd8,  2'b11, 1'b0, 1, 10};
        vecs[4] = '{8'hA5, 4'd3,  2'b00, 1'b0, 1, 10};
        vecs[5] = '{8'h1F, 4'd5,  2'b10, 1'b1, 2,  9};
        vecs[6] = '{8'hFF, 4'd15, 2'b01, 1'b0, 3, 11};
        vecs[7] = '{8'h80, 4'd6,  2'b00, 1'b1, 1,  9};

        tick = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk1("reset_tx", Tx, 1'b1);
        chk1("reset_ready", TxReady, 1'b1);
        chk1("reset_busy", Busy, 1'b0);
        chk1("reset_txdone", TxDone, 1'b0);
        Rst_n = 1'b1;
        idle(5);

        foreach (vecs[i]) begin
            frame(vecs[i].d, vecs[i].nb, vecs[i].pm, vecs[i].sb, vecs[i].period, 1'b0, dc);
            chkn("frame_length_cycles", dc, (vecs[i].exp_len * OS - 1) * vecs[i].period + 1);
            idle(3);
        end

        // Back-to-back with TxValid held: exactly one IDLE cycle between frames.
        frame(8'h3A, 4'd8, 2'b01, 1'b0, 4, 1'b1, dc);
        chkn("b2b_first_len", dc, (11 * OS - 1) * 4 + 1);
        frame(8'hC5, 4'd6, 2'b10, 1'b1, 4, 1'b0, dc);
        chkn("b2b_second_len", dc, (10 * OS - 1) * 4 + 1);
        idle(3);

        // Asynchronous reset during the data bits of a 0x00 frame.
        TxData = 8'h00; nBits = 4'd8; ParityMode = 2'b00; StopBits = 1'b0;
        TxValid = 1'b1;
        tick = 1'b1;
        @(posedge Clk); #1;
        TxValid = 1'b0;
        repeat (40) @(posedge Clk);
        #1;
        chk1("pre_reset_tx_data", Tx, 1'b0);
        chk1("pre_reset_busy", Busy, 1'b1);
        Rst_n = 1'b0;
        #1;
        chk1("async_reset_tx", Tx, 1'b1);
        chk1("async_reset_ready", TxReady, 1'b1);
        chk1("async_reset_busy", Busy, 1'b0);
        chk1("async_reset_txdone", TxDone, 1'b0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        idle(200);
        frame(8'h96, 4'd8, 2'b01, 1'b1, 1, 1'b0, dc);
        chkn("post_reset_len", dc, 12 * OS);
        idle(2);

        hold = 1'b0;
        for (int i = 0; i < 25; i++) begin
            frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                  $urandom_range(0, 3), hold, dc);
            hold = 1'($urandom);
            if (!hold) idle($urandom_range(1, 4));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
